// File: rtl/menger_sponge_sdf.sv
// -----------------------------------------------------------------------------
// menger_sponge_sdf
//   Sequential fixed-point signed-distance evaluator for a Menger sponge
//   centred at the origin. It takes one Q16.16 point and returns a
//   conservative distance bound and an orbit-trap colour, with a fixed
//   latency of 2 + 43*ITERATIONS edges from the edge that samples sdf_start.
//
//   Handshake: sdf_start is sampled only in IDLE. sdf_done rises when the
//   result is ready and stays high, with the outputs frozen, for as long as
//   sdf_start is held high. It drops on the edge after sdf_start goes low,
//   and the outputs keep their last values.
//
//   Optional feature macro: MENGER_TRAP_COLOR_EN
//     defined   - colours follow the orbit-trap level map
//     undefined - trap logic removed, colours are 255 once a result is ready
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous active-low reset
//   sdf_start       level request
//   x, y, z         point, signed Q16.16
//   sdf_done        result valid
//   sdf_out         signed Q16.16 distance bound (saturated to +/-(2^31-1))
//   sdf_*_out       trap colour channels
// -----------------------------------------------------------------------------
module menger_sponge_sdf #(
    parameter int HALF_SIZE  = 20,
    parameter int ITERATIONS = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sdf_start,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic        sdf_done,
    output logic [31:0] sdf_out,
    output logic [7:0]  sdf_red_out,
    output logic [7:0]  sdf_green_out,
    output logic [7:0]  sdf_blue_out
);

    localparam logic signed [39:0] L_Q   = 40'(HALF_SIZE) <<< 16;
    localparam logic        [39:0] TWO_L = 40'(HALF_SIZE) << 17;

    typedef enum logic [2:0] {
        S_IDLE, S_BOX, S_MUL, S_MOD, S_FOLD, S_COMB, S_OUT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic             [31:0] p_q   [3];
    logic             [31:0] p_d   [3];
    logic             [39:0] mag_q [3];
    logic             [39:0] mag_d [3];
    logic             [39:0] rem_q [3];
    logic             [39:0] rem_d [3];
    logic                    neg_q [3];
    logic                    neg_d [3];
    logic signed      [39:0] r_q   [3];
    logic signed      [39:0] r_d   [3];
    logic signed      [39:0] d_q, d_d;
    logic             [7:0]  s_q, s_d;
    logic             [2:0]  lvl_q, lvl_d;
    logic             [5:0]  cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic             [31:0] out_q, out_d;
    logic             [7:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
`ifdef MENGER_TRAP_COLOR_EN
    logic             [2:0]  trap_q, trap_d;
`endif

    // ---------------- datapath helpers ----------------
    logic             [32:0] abs_p [3];
    logic             [32:0] max_abs;
    logic signed      [39:0] v     [3];
    logic             [39:0] v_abs [3];
    logic             [40:0] trial [3];
    logic             [39:0] rem_next [3];
    logic             [39:0] m     [3];
    logic signed      [39:0] a     [3];
    logic signed      [39:0] abs_a [3];
    logic signed      [39:0] e     [3];
    logic signed      [39:0] r_calc [3];
    logic signed      [39:0] mx01, mx12, mx20, t_val, c_val;
    logic             [31:0] recip;
    logic signed      [79:0] prod;
    logic             [31:0] sat_val;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            // 33-bit magnitude so |-2^31| does not overflow
            abs_p[i] = p_q[i][31] ? (33'd0 - {p_q[i][31], p_q[i]}) : {1'b0, p_q[i]};
            v[i]     = $signed({{8{p_q[i][31]}}, p_q[i]}) * $signed({32'd0, s_q});
            v_abs[i] = v[i][39] ? 40'(-v[i]) : v[i];
            // one restoring-division step on the magnitude
            trial[i] = {rem_q[i], mag_q[i][39]};
            if (trial[i] >= {1'b0, TWO_L}) begin
                rem_next[i] = 40'(trial[i] - {1'b0, TWO_L});
            end else begin
                rem_next[i] = trial[i][39:0];
            end
            // floored modulo: a negative dividend with nonzero remainder wraps
            m[i]      = (neg_q[i] && (rem_q[i] != 40'd0)) ? (TWO_L - rem_q[i]) : rem_q[i];
            a[i]      = $signed(m[i]) - L_Q;
            abs_a[i]  = a[i][39] ? -a[i] : a[i];
            e[i]      = L_Q - (40'sd3 * abs_a[i]);
            r_calc[i] = e[i][39] ? -e[i] : e[i];
        end
        max_abs = abs_p[0];
        if (abs_p[1] > max_abs) max_abs = abs_p[1];
        if (abs_p[2] > max_abs) max_abs = abs_p[2];

        // min of pairwise maxima selects the middle value of the three
        mx01  = (r_q[0] > r_q[1]) ? r_q[0] : r_q[1];
        mx12  = (r_q[1] > r_q[2]) ? r_q[1] : r_q[2];
        mx20  = (r_q[2] > r_q[0]) ? r_q[2] : r_q[0];
        t_val = mx01;
        if (mx12 < t_val) t_val = mx12;
        if (mx20 < t_val) t_val = mx20;
        t_val = t_val - L_Q;

        // round(2^32 / 3^k)
        case (lvl_q)
            3'd1:    recip = 32'd1431655765;
            3'd2:    recip = 32'd477218588;
            3'd3:    recip = 32'd159072863;
            3'd4:    recip = 32'd53024288;
            3'd5:    recip = 32'd17674763;
            default: recip = 32'd0;
        endcase
        prod  = $signed({{40{t_val[39]}}, t_val}) * $signed({48'd0, recip});
        c_val = 40'(prod >>> 32);

        if (d_q > 40'sd2147483647) begin
            sat_val = 32'h7FFF_FFFF;
        end else if (d_q < -40'sd2147483647) begin
            sat_val = 32'h8000_0001;
        end else begin
            sat_val = d_q[31:0];
        end
    end

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        mag_d   = mag_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        r_d     = r_q;
        d_d     = d_q;
        s_d     = s_q;
        lvl_d   = lvl_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        out_d   = out_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
`ifdef MENGER_TRAP_COLOR_EN
        trap_d  = trap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sdf_start) begin
                    p_d[0]  = x;
                    p_d[1]  = y;
                    p_d[2]  = z;
                    state_d = S_BOX;
                end
            end
            S_BOX: begin
                d_d     = $signed({7'd0, max_abs}) - L_Q;
                s_d     = 8'd1;
                lvl_d   = 3'd1;
`ifdef MENGER_TRAP_COLOR_EN
                trap_d  = 3'd0;
`endif
                state_d = S_MUL;
            end
            S_MUL: begin
                for (int i = 0; i < 3; i++) begin
                    mag_d[i] = v_abs[i];
                    neg_d[i] = v[i][39];
                    rem_d[i] = 40'd0;
                end
                cnt_d   = 6'd0;
                state_d = S_MOD;
            end
            S_MOD: begin
                for (int i = 0; i < 3; i++) begin
                    rem_d[i] = rem_next[i];
                    mag_d[i] = mag_q[i] << 1;
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd39) state_d = S_FOLD;
            end
            S_FOLD: begin
                r_d     = r_calc;
                state_d = S_COMB;
            end
            S_COMB: begin
                // strict compare: on a tie the earlier level keeps the trap
                if (c_val > d_q) begin
                    d_d    = c_val;
`ifdef MENGER_TRAP_COLOR_EN
                    trap_d = lvl_q;
`endif
                end
                s_d     = 8'(s_q * 8'd3);
                lvl_d   = lvl_q + 3'd1;
                state_d = (lvl_q == 3'(ITERATIONS)) ? S_OUT : S_MUL;
            end
            S_OUT: begin
                out_d = sat_val;
`ifdef MENGER_TRAP_COLOR_EN
                case (trap_q)
                    3'd0:    begin red_d = 8'd200; green_d = 8'd200; blue_d = 8'd200; end
                    3'd1:    begin red_d = 8'd255; green_d = 8'd64;  blue_d = 8'd64;  end
                    3'd2:    begin red_d = 8'd64;  green_d = 8'd255; blue_d = 8'd64;  end
                    default: begin red_d = 8'd64;  green_d = 8'd64;  blue_d = 8'd255; end
                endcase
`else
                red_d   = 8'd255;
                green_d = 8'd255;
                blue_d  = 8'd255;
`endif
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!sdf_start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            p_q     <= '{default: '0};
            mag_q   <= '{default: '0};
            rem_q   <= '{default: '0};
            neg_q   <= '{default: '0};
            r_q     <= '{default: '0};
            d_q     <= '0;
            s_q     <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
`ifdef MENGER_TRAP_COLOR_EN
            trap_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            mag_q   <= mag_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            r_q     <= r_d;
            d_q     <= d_d;
            s_q     <= s_d;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
`ifdef MENGER_TRAP_COLOR_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign sdf_done      = done_q;
    assign sdf_out       = out_q;
    assign sdf_red_out   = red_q;
    assign sdf_green_out = green_q;
    assign sdf_blue_out  = blue_q;

endmodule

// File: tb/tb_menger_sponge_sdf.sv
// -----------------------------------------------------------------------------
// tb_menger_sponge_sdf
//   Self-checking bench for menger_sponge_sdf: a table of known points, a
//   handshake hold/drop sequence, randomized points checked against an
//   arithmetic reference model, and a reset applied mid-computation.
//   Valid/ready here is a level handshake: sdf_start is raised with stable
//   x/y/z, sdf_done answers and stays up until sdf_start falls.
// -----------------------------------------------------------------------------
module tb_menger_sponge_sdf;

    localparam int HALF_SIZE  = 20;
    localparam int ITERATIONS = 3;
    localparam int LATENCY    = 2 + 43 * ITERATIONS;

    logic        clk_in;
    logic        rst_in;
    logic        sdf_start;
    logic [31:0] x, y, z;
    logic        sdf_done;
    logic [31:0] sdf_out;
    logic [7:0]  sdf_red_out, sdf_green_out, sdf_blue_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_col_q[$];

    menger_sponge_sdf #(
        .HALF_SIZE  (HALF_SIZE),
        .ITERATIONS (ITERATIONS)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .sdf_start     (sdf_start),
        .x             (x),
        .y             (y),
        .z             (z),
        .sdf_done      (sdf_done),
        .sdf_out       (sdf_out),
        .sdf_red_out   (sdf_red_out),
        .sdf_green_out (sdf_green_out),
        .sdf_blue_out  (sdf_blue_out)
    );

    // ---------------- clock ----------------
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    function automatic longint labs(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic longint lmax(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    function automatic longint recip_of(input int k);
        longint p3 = 1;
        for (int i = 0; i < k; i++) p3 = p3 * 3;
        return ((longint'(1) <<< 33) + p3) / (2 * p3);
    endfunction

    function automatic logic [31:0] colour_of(input int trap);
        logic [31:0] col;
        case (trap)
            0:       col = 32'h00C8C8C8;
            1:       col = 32'h00FF4040;
            2:       col = 32'h0040FF40;
            default: col = 32'h004040FF;
        endcase
`ifndef MENGER_TRAP_COLOR_EN
        col = 32'h00FFFFFF;
`endif
        return col;
    endfunction

    function automatic void model(input logic [31:0] px, input logic [31:0] py,
                                  input logic [31:0] pz, output logic [31:0] dout,
                                  output int trap);
        longint l_q, two_l, d, s, v, m, a, e, t, c, mx;
        longint p[3];
        longint r[3];
        l_q   = longint'(HALF_SIZE) * 65536;
        two_l = 2 * l_q;
        p[0]  = longint'($signed(px));
        p[1]  = longint'($signed(py));
        p[2]  = longint'($signed(pz));
        mx    = lmax(labs(p[0]), lmax(labs(p[1]), labs(p[2])));
        d     = mx - l_q;
        trap  = 0;
        s     = 1;
        for (int k = 1; k <= ITERATIONS; k++) begin
            for (int i = 0; i < 3; i++) begin
                v = p[i] * s;
                m = v % two_l;
                if (m < 0) m = m + two_l;
                a = m - l_q;
                e = l_q - 3 * labs(a);
                r[i] = labs(e);
            end
            t = lmin(lmax(r[0], r[1]), lmin(lmax(r[1], r[2]), lmax(r[2], r[0]))) - l_q;
            c = (t * recip_of(k)) >>> 32;
            if (c > d) begin
                d    = c;
                trap = k;
            end
            s = s * 3;
        end
        if (d > 64'sd2147483647)       dout = 32'h7FFF_FFFF;
        else if (d < -64'sd2147483647) dout = 32'h8000_0001;
        else                           dout = 32'(d);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic [31:0] got,
                             input logic [31:0] exp, input int tol);
        longint diff;
        n_checks++;
        diff = longint'($signed(got)) - longint'($signed(exp));
        if (labs(diff) > tol || $isunknown(got)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, $signed(got), $signed(exp), tol);
        end
    endtask

    // ---------------- drivers ----------------
    // Raise start with the point; count edges after the sampling edge until done.
    task automatic do_request(input logic [31:0] px, input logic [31:0] py,
                              input logic [31:0] pz, output int lat);
        @(negedge clk_in);
        x = px;
        y = py;
        z = pz;
        sdf_start = 1'b1;
        @(posedge clk_in);
        lat = 0;
        do begin
            @(posedge clk_in);
            #1;
            lat++;
        end while (!sdf_done && lat < 400);
    endtask

    task automatic release_start(input string name);
        @(negedge clk_in);
        sdf_start = 1'b0;
        @(posedge clk_in);
        #1;
        check(name, {31'd0, sdf_done}, 32'd0);
    endtask

    function automatic logic [31:0] colour_out();
        return {8'd0, sdf_red_out, sdf_green_out, sdf_blue_out};
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] exp_out;
        int          tol;
        int          exp_trap;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int          lat;
        int          trap;
        logic [31:0] mexp;
        logic [31:0] exp_v;
        logic [31:0] exp_c;
        logic [31:0] rx, ry, rz;

        rst_in    = 1'b0;
        sdf_start = 1'b0;
        x = '0;
        y = '0;
        z = '0;

        vecs[0] = '{32'd0,            32'd0,            32'd23 << 16,     32'h0006AAAA, 2, 1};
        vecs[1] = '{32'd19 << 16,     32'd19 << 16,     32'd19 << 16,     -32'sd31554,  4, 3};
        vecs[2] = '{32'd100 << 16,    32'd0,            32'd0,            32'h00500000, 0, 0};
        vecs[3] = '{32'd0,            32'd0,            32'd0,            32'h0006AAAA, 2, 1};

        repeat (3) @(posedge clk_in);
        #1;
        check("reset_done", {31'd0, sdf_done}, 32'd0);
        check("reset_out", sdf_out, 32'd0);
        check("reset_colour", colour_out(), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Table of known points from the sponge geometry.
        for (int i = 0; i < 4; i++) begin
            model(vecs[i].x, vecs[i].y, vecs[i].z, mexp, trap);
            do_request(vecs[i].x, vecs[i].y, vecs[i].z, lat);
            check($sformatf("vec%0d_latency", i), lat, LATENCY);
            check_tol($sformatf("vec%0d_out", i), sdf_out, vecs[i].exp_out, vecs[i].tol);
            check($sformatf("vec%0d_model", i), sdf_out, mexp);
            check($sformatf("vec%0d_colour", i), colour_out(), colour_of(vecs[i].exp_trap));
            if (i == 0) begin
                // Start held high: result must stay frozen.
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk_in);
                    #1;
                    check("hold_done", {31'd0, sdf_done}, 32'd1);
                    check("hold_out", sdf_out, mexp);
                end
            end
            release_start($sformatf("vec%0d_drop", i));
            check($sformatf("vec%0d_out_kept", i), sdf_out, mexp);
        end

        // Randomized points against the model through the scoreboard.
        for (int n = 0; n < 20; n++) begin
            if (n % 5 == 4) begin
                rx = $urandom();
                ry = $urandom();
                rz = $urandom();
            end else begin
                rx = $urandom_range(0, 32'd7864320) - 32'd3932160;
                ry = $urandom_range(0, 32'd7864320) - 32'd3932160;
                rz = $urandom_range(0, 32'd7864320) - 32'd3932160;
            end
            model(rx, ry, rz, mexp, trap);
            exp_q.push_back(mexp);
            exp_col_q.push_back(colour_of(trap));
            do_request(rx, ry, rz, lat);
            check("rand_latency", lat, LATENCY);
            exp_v = exp_q.pop_front();
            exp_c = exp_col_q.pop_front();
            check("rand_out", sdf_out, exp_v);
            check("rand_colour", colour_out(), exp_c);
            release_start("rand_drop");
        end

        // Extreme coordinate: |x| = 2^31 exercises the wide abs path.
        model(32'h8000_0000, 32'd5 << 16, 32'd0, mexp, trap);
        do_request(32'h8000_0000, 32'd5 << 16, 32'd0, lat);
        check("extreme_out", sdf_out, mexp);
        check("extreme_colour", colour_out(), colour_of(trap));
        release_start("extreme_drop");

        // Reset in the middle of a computation, then a fresh request.
        @(negedge clk_in);
        x = 32'd100 << 16;
        y = 32'd0;
        z = 32'd0;
        sdf_start = 1'b1;
        @(posedge clk_in);
        repeat (50) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        check("midrst_done", {31'd0, sdf_done}, 32'd0);
        check("midrst_out", sdf_out, 32'd0);
        check("midrst_colour", colour_out(), 32'd0);
        @(negedge clk_in);
        x = 32'd19 << 16;
        y = 32'd19 << 16;
        z = 32'd19 << 16;
        rst_in = 1'b1;
        model(x, y, z, mexp, trap);
        @(posedge clk_in);
        lat = 0;
        do begin
            @(posedge clk_in);
            #1;
            lat++;
        end while (!sdf_done && lat < 400);
        check("postrst_latency", lat, LATENCY);
        check("postrst_out", sdf_out, mexp);
        check("postrst_colour", colour_out(), colour_of(trap));
        release_start("postrst_drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/menger_sponge_sdf.md
Name: menger_sponge_sdf

Overview:
Sequential fixed-point signed-distance evaluator for a Menger sponge centred at the origin, used by the ray marcher.
- Takes one Q16.16 point and returns a conservative distance bound plus an orbit-trap colour.
- Uses a level start/done handshake and has a fixed latency.

Parameters:
HALF_SIZE, 20, sponge half-extent L in integer world units (Q16.16 value = HALF_SIZE<<16)
ITERATIONS, 3, number of fold levels k=1..ITERATIONS; legal range 1..5

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
sdf_start  input  1  level request; sampled only in IDLE
x  input  32  point x, signed Q16.16
y  input  32  point y, signed Q16.16
z  input  32  point z, signed Q16.16
sdf_done  output  1  result valid; held until sdf_start is low
sdf_out  output  32  signed Q16.16 distance bound
sdf_red_out  output  8  trap colour red
sdf_green_out  output  8  trap colour green
sdf_blue_out  output  8  trap colour blue

Behaviour:
- Reset (rst_in=0, any time including mid-computation): FSM goes to IDLE; sdf_done=0, sdf_out=0, all colour outputs=0; internal registers are cleared.
- IDLE: when sdf_start=1, latch x, y, z and go to BOX.
- BOX (1 cycle): d = max(|x|,|y|,|z|) - L (Chebyshev box bound); trap=0; s=1.
- Per level k (s=3^(k-1) on entry):
  - MUL (1 cycle): v = p*s per axis, 40-bit signed.
  - MOD (40 cycles, restoring, 1 bit/cycle, three axes in parallel): m = floored v mod 2L, result in [0, 2L).
  - FOLD (1 cycle): a = m - L; r = |L - 3|a||.
  - COMB (1 cycle):
    - t = min(max(rx,ry), max(ry,rz), max(rz,rx)) - L.
    - c = t * RECIP[k] >>> 32, with RECIP[k] = round(2^32/3^k).
    - If c > d (strictly), then d = c and trap = k. Ties keep the earlier level.
- After the last level, go to DONE: register sdf_out=d and the colours; sdf_done=1.
- Latency: sdf_done rises exactly 2+43*ITERATIONS edges after the edge that sampled sdf_start (131 for defaults).
- DONE: outputs are held stable while sdf_start=1. On sdf_start=0, sdf_done drops next edge, FSM returns to IDLE, and sdf_out and the colours keep their last values.
- A new request requires sdf_start low for at least one cycle after DONE.
- Arithmetic:
  - Two's complement, truncation toward -inf on shifts.
  - abs uses 33-bit internal values, so no overflow for |coord| < 2^31.
  - Final result is truncated to 32 bits with saturation at ±(2^31-1).
- Colour map (trap → R,G,B): 0 → 200,200,200; 1 → 255,64,64; 2 → 64,255,64; ≥3 → 64,64,255.

Optional Feature:
MENGER_TRAP_COLOR_EN:
- Defined: colours follow the trap map above.
- Undefined: trap logic is omitted and sdf_red_out, sdf_green_out and sdf_blue_out are constant 255 in DONE (0 after reset). Distance and latency are unchanged.

Test Plan:
- x=0, y=0, z=23.0, start held until done → sdf_done at edge 131; sdf_out ≈ 6.6667 (0x0006AAAA ±2 LSB, integer part 6); colour 255,64,64.
- x=y=z=19.0 → sdf_out ≈ -0.48148 (≈ -31554 LSB ±4); colour 64,64,255 (level 3 strictly wins).
- x=100.0, y=z=0 → sdf_out = 0x00500000 (80.0) exactly; colour 200,200,200.
- Origin (0,0,0) → sdf_out ≈ 6.6667; colour 255,64,64.
- Handshake and back-to-back:
  - Keep start high 10 cycles after done → sdf_done and outputs stay stable.
  - Drop start → sdf_done=0 next edge.
  - Second request after one idle cycle → correct new result.
- Reset mid-computation: assert rst_in low at cycle 50 → outputs 0 immediately.
  - Release with start high → fresh computation, done 131 edges later with correct value.
